// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : serial_add_ctrl (with leaf cell fa)
//  Purpose  : Bit-serial add/subtract unit. A single 1-bit full adder is
//             stepped LSB-first over WIDTH clock cycles, so one adder cell
//             serves every bit position of the operands.
//  Ports    : clk       - rising-edge clock
//             reset_n   - asynchronous active-low reset
//             start     - request, accepted only in IDLE or DONE
//             sub       - 0: a+b, 1: a-b (sampled with start)
//             a, b      - WIDTH-bit operands (sampled with start)
//             busy      - high while an operation is running
//             done      - one-cycle completion pulse
//             result    - sum/difference, held until the next completion
//             cout      - final carry out (sub: 1 means a>=b unsigned)
//             overflow  - signed overflow of the completed operation
//  Revision : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  fa : 1-bit full adder
// ----------------------------------------------------------------------------
module fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

// ----------------------------------------------------------------------------
//  serial_add_ctrl : sequencer around the shared full adder
// ----------------------------------------------------------------------------
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int                 CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   opa_q;
    logic [WIDTH-1:0]   opb_q;
    logic [WIDTH-1:0]   acc_q;      // sum bits enter at the MSB and walk down
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   result_q;
    logic               cout_q;
    logic               ovf_q;

    // Combinational outputs of the shared adder cell
    logic               sum_d;
    logic               carry_d;

    fa u_fa (
        .a_i (opa_q[0]),
        .b_i (opb_q[0]),
        .c_i (carry_q),
        .s_o (sum_d),
        .c_o (carry_d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + 1; the +1 rides in as carry-in.
                        opa_q   <= a;
                        opb_q   <= sub ? ~b : b;
                        carry_q <= sub;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    acc_q   <= {sum_d, acc_q[WIDTH-1:1]};
                    opa_q   <= {1'b0, opa_q[WIDTH-1:1]};
                    opb_q   <= {1'b0, opb_q[WIDTH-1:1]};
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        // carry_q here is the carry into the MSB.
                        result_q <= {sum_d, acc_q[WIDTH-1:1]};
                        cout_q   <= carry_d;
                        ovf_q    <= carry_q ^ carry_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_add_ctrl
//  Purpose  : Directed self-checking bench for serial_add_ctrl (WIDTH=8)
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_serial_add_ctrl;

    localparam int C_WIDTH = 8;

    logic               clk;
    logic               reset_n;
    logic               start;
    logic               sub;
    logic [C_WIDTH-1:0] a;
    logic [C_WIDTH-1:0] b;
    logic               busy;
    logic               done;
    logic [C_WIDTH-1:0] result;
    logic               cout;
    logic               overflow;

    int n_cmp = 0;
    int n_err = 0;

    serial_add_ctrl #(.WIDTH(C_WIDTH)) u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a request before an edge; returns 1ns after the accept edge.
    task automatic start_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts);
        @(negedge clk);
        a = ta; b = tb_v; sub = ts; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges after the accept edge until done is seen (bounded).
    task automatic wait_done(output int lat);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic check_op(input string tag, input logic [7:0] er,
                            input logic ec, input logic ev);
        check({tag, ".result"}, {24'd0, result}, {24'd0, er});
        check({tag, ".cout"},   {31'd0, cout},   {31'd0, ec});
        check({tag, ".ovf"},    {31'd0, overflow}, {31'd0, ev});
    endtask

    // Reference arithmetic, independent of the serial structure.
    task automatic ref_model(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts,
                             output logic [7:0] r, output logic c, output logic v);
        logic [8:0] full;
        if (!ts) begin
            full = {1'b0, ta} + {1'b0, tb_v};
            r = full[7:0];
            c = full[8];
            v = (ta[7] == tb_v[7]) && (r[7] != ta[7]);
        end else begin
            r = ta - tb_v;
            c = (ta >= tb_v);
            v = (ta[7] != tb_v[7]) && (r[7] != ta[7]);
        end
    endtask

    initial begin : main
        int          lat;
        int          ndone;
        logic [7:0]  er;
        logic        ec;
        logic        ev;
        logic [7:0]  prev;
        logic [7:0]  bvals [8];

        reset_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        #2;
        check("rst.busy",   {31'd0, busy},     32'd0);
        check("rst.done",   {31'd0, done},     32'd0);
        check("rst.result", {24'd0, result},   32'd0);
        check("rst.cout",   {31'd0, cout},     32'd0);
        check("rst.ovf",    {31'd0, overflow}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Test 1 + 4a: 0x35+0x4A with a start re-pulse during RUN cycle 3
        start_op(8'h35, 8'h4A, 1'b0);
        check("t1.busy_after_accept", {31'd0, busy}, 32'd1);
        lat = 0; ndone = 0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 3) begin
                @(negedge clk);
                start = 1'b1; a = 8'hAA; b = 8'h55; sub = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                ndone++;
                if (lat == 0) lat = k;
                check("t1.busy_with_done", {31'd0, busy}, 32'd0);
                check_op("t1", 8'h7F, 1'b0, 1'b0);
            end
        end
        check("t1.latency", lat, 32'd8);
        check("t4.single_done", ndone, 32'd1);
        check_op("t1.held", 8'h7F, 1'b0, 1'b0);

        // Test 2: carry and signed overflow on add
        start_op(8'hFF, 8'h01, 1'b0);
        check("t2.result_stable_in_run", {24'd0, result}, 32'h7F);
        wait_done(lat);
        check("t2a.latency", lat, 32'd8);
        check_op("t2a", 8'h00, 1'b1, 1'b0);

        // Test 4b: start presented in DONE is accepted at that edge
        start_op(8'h7F, 8'h01, 1'b0);
        check("t4.b2b.busy", {31'd0, busy}, 32'd1);
        check("t4.b2b.done", {31'd0, done}, 32'd0);
        check("t4.b2b.result_held", {24'd0, result}, 32'h00);
        wait_done(lat);
        check("t2b.latency", lat, 32'd8);
        check_op("t2b", 8'h80, 1'b0, 1'b1);

        // Test 3: subtraction
        start_op(8'h10, 8'h20, 1'b1);
        wait_done(lat);
        check_op("t3a", 8'hF0, 1'b0, 1'b0);
        start_op(8'h80, 8'h01, 1'b1);
        wait_done(lat);
        check_op("t3b", 8'h7F, 1'b1, 1'b1);

        // Idle gap: outputs hold
        repeat (4) @(posedge clk);
        #1;
        check("idle.done", {31'd0, done}, 32'd0);
        check_op("idle.hold", 8'h7F, 1'b1, 1'b1);

        // Test 5: reset during RUN cycle 4
        start_op(8'h12, 8'h34, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5.busy",   {31'd0, busy}, 32'd0);
        check("t5.done",   {31'd0, done}, 32'd0);
        check_op("t5.async", 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("t5.no_done", ndone, 32'd0);
        start_op(8'h01, 8'h01, 1'b0);
        wait_done(lat);
        check("t5.latency", lat, 32'd8);
        check_op("t5.fresh", 8'h02, 1'b0, 1'b0);

        // Test 6: sweep a over a stride with corner b values, both ops, back-to-back
        bvals = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h55, 8'hAA, 8'h13};
        for (int ia = 0; ia < 256; ia += 7) begin
            for (int ib = 0; ib < 8; ib++) begin
                for (int s = 0; s < 2; s++) begin
                    prev = result;
                    start_op(8'(ia), bvals[ib], s[0]);
                    if (result !== prev)
                        check("t6.result_changed_at_accept", {24'd0, result}, {24'd0, prev});
                    wait_done(lat);
                    if (lat != 8) check("t6.latency", lat, 32'd8);
                    ref_model(8'(ia), bvals[ib], s[0], er, ec, ev);
                    check_op($sformatf("t6[%0h%s%0h]", ia, s[0] ? "-" : "+", bvals[ib]),
                             er, ec, ev);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always ends with a summary.
    initial begin
        #2000000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
